mult_issue: RTL and testbench

- Issue/retire stage directly upstream and downstream of the Karatsuba/Booth multiplier (MULT).
- Accepts a decoded M-extension multiply request over a valid/ready handshake and holds operands and codif stable into MULT.
- Sequences MULT's Enable so its three Booth FSMs start and then return to idle.
- Captures rd on Done and presents a tagged result to writeback over a valid/ready handshake.
- Handles the all-zero-operand case, which MULT never completes because its internal enable is gated off, plus illegal codif, timeout and flush.

---
 rtl/mriscv_mul_pkg.sv | 24 ++
 rtl/mult_issue_if.sv | 52 +++++
 rtl/mult_issue.sv | 146 ++++++++++++++
 tb/tb_mult_issue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mriscv_mul_pkg.sv
// Shared M-extension multiply definitions: codif encodings seen by the
// decoder, the issue stage and MULT, plus the issue-stage state encoding.
package mriscv_mul_pkg;

  localparam logic [11:0] CODIF_MUL    = 12'b010000110011;
  localparam logic [11:0] CODIF_MULH   = 12'b010010110011;
  localparam logic [11:0] CODIF_MULHSU = 12'b010100110011;
  localparam logic [11:0] CODIF_MULHU  = 12'b010110110011;
  localparam logic [11:0] CODIF_NOP    = 12'h000;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    RESP
  } state_e;

  function automatic logic codif_legal(input logic [11:0] codif);
    return (codif == CODIF_MUL)    || (codif == CODIF_MULH) ||
           (codif == CODIF_MULHSU) || (codif == CODIF_MULHU);
  endfunction

endpackage

// File: rtl/mult_issue_if.sv
// Bundle of the request, MULT-side and writeback-side signals of the
// multiply issue stage. The stage itself uses the slave view.
interface mult_issue_if #(
  parameter int TAG_W = 5
);

  logic             flush;
  logic             busy;

  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [11:0]      req_codif;
  logic [TAG_W-1:0] req_tag;

  logic             mul_enable;
  logic [31:0]      mul_rs1;
  logic [31:0]      mul_rs2;
  logic [11:0]      mul_codif;
  logic [31:0]      mul_rd;
  logic             mul_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport slave (
    input  flush,
    input  req_valid, req_rs1, req_rs2, req_codif, req_tag,
    input  mul_rd, mul_done,
    input  rsp_ready,
    output busy,
    output req_ready,
    output mul_enable, mul_rs1, mul_rs2, mul_codif,
    output rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport master (
    output flush,
    output req_valid, req_rs1, req_rs2, req_codif, req_tag,
    output mul_rd, mul_done,
    output rsp_ready,
    input  busy,
    input  req_ready,
    input  mul_enable, mul_rs1, mul_rs2, mul_codif,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err
  );

endinterface

// File: rtl/mult_issue.sv
// Issue/retire stage around the Booth/Karatsuba multiplier: holds operands
// into MULT, sequences its Enable, and returns a tagged result to writeback.
module mult_issue
  import mriscv_mul_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 48,
  parameter int TMO_W   = 6
) (
  input logic         clk,
  input logic         reset,
  mult_issue_if.slave bus
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [11:0]      codif_q, codif_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      codif_q <= CODIF_NOP;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      codif_q <= codif_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
    end
  end

  // Illegal and zero-operand requests never reach MULT: it would not finish
  // a zero-operand op because its internal enable is gated off.
  always_comb begin
    state_d = state_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    codif_d = codif_q;
    tag_d   = tag_q;
    data_d  = data_q;
    err_d   = err_q;
    drop_d  = drop_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          tag_d  = bus.req_tag;
          cnt_d  = '0;
          drop_d = 1'b0;
          if (!codif_legal(bus.req_codif)) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (bus.req_rs1 == 32'd0 || bus.req_rs2 == 32'd0) begin
            data_d  = '0;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            rs1_d   = bus.req_rs1;
            rs2_d   = bus.req_rs2;
            codif_d = bus.req_codif;
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (bus.flush) begin
          drop_d  = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (bus.flush) begin
          drop_d  = 1'b1;
          state_d = DRAIN;
        end else if (bus.mul_done) begin
          data_d  = bus.mul_rd;
          err_d   = 1'b0;
          state_d = DRAIN;
        end else if (cnt_q == TMO_LAST) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = DRAIN;
        end
      end

      // Enable is low here so every Booth FSM falls back to idle before
      // MULT sees the NOP codif again.
      DRAIN: begin
        cnt_d   = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        codif_d = CODIF_NOP;
        drop_d  = 1'b0;
        state_d = (drop_q || bus.flush) ? IDLE : RESP;
      end

      RESP: begin
        if (bus.flush || bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE) && !bus.flush;
    bus.mul_enable = (state_q == ISSUE) || (state_q == WAIT);
    bus.mul_rs1    = rs1_q;
    bus.mul_rs2    = rs2_q;
    bus.mul_codif  = codif_q;
    bus.rsp_valid  = (state_q == RESP);
    bus.rsp_data   = data_q;
    bus.rsp_tag    = tag_q;
    bus.rsp_err    = err_q;
    bus.busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mult_issue.sv
// Directed bench for mult_issue with a small behavioural MULT standing in
// for the real multiplier (fixed latency, done held until Enable drops).
module tb_mult_issue;
  import mriscv_mul_pkg::*;

  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 48;
  localparam int TMO_W   = 6;
  localparam int MUL_LAT = 2;

  typedef struct {
    logic [11:0]      codif;
    logic [31:0]      rs1;
    logic [31:0]      rs2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      expData;
    logic             expErr;
    int               expLat;
    int               expEnCycles;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tieDoneLow = 1'b0;
  int   mulCnt;
  int   compared = 0;
  int   mismatched = 0;
  vec_t vecs[9];

  mult_issue_if #(.TAG_W(TAG_W)) bus ();

  mult_issue #(
    .TAG_W  (TAG_W),
    .TIMEOUT(TIMEOUT),
    .TMO_W  (TMO_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelRd(input logic [11:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    p  = '0;
    case (c)
      CODIF_MUL:    begin p = za * zb; return p[31:0];  end
      CODIF_MULH:   begin p = sa * sb; return p[63:32]; end
      CODIF_MULHSU: begin p = sa * zb; return p[63:32]; end
      CODIF_MULHU:  begin p = za * zb; return p[63:32]; end
      default:      return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset || !bus.mul_enable) begin
      mulCnt       <= 0;
      bus.mul_done <= 1'b0;
    end else if (!tieDoneLow) begin
      if (mulCnt == MUL_LAT) bus.mul_done <= 1'b1;
      else mulCnt <= mulCnt + 1;
    end
  end

  always_comb bus.mul_rd = modelRd(bus.mul_codif, bus.mul_rs1, bus.mul_rs2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Leaves the caller at the first falling edge after the accepting edge.
  task automatic applyStimulus(input logic [11:0] codif, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [TAG_W-1:0] tag);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_codif = codif;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_tag   = tag;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic waitResp(output int lat, output int enCyc);
    lat   = 1;
    enCyc = 0;
    while (!bus.rsp_valid && lat < 200) begin
      if (bus.mul_enable) enCyc++;
      @(negedge clk);
      lat++;
    end
    check("rsp_valid_arrives", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic checkOutput(input string tagName, input vec_t v, input int lat, input int enCyc);
    check({tagName, "_data"},   bus.rsp_data, v.expData);
    check({tagName, "_err"},    32'(bus.rsp_err), 32'(v.expErr));
    check({tagName, "_tag"},    32'(bus.rsp_tag), 32'(v.tag));
    check({tagName, "_lat"},    32'(lat), 32'(v.expLat));
    check({tagName, "_enCyc"},  32'(enCyc), 32'(v.expEnCycles));
    check({tagName, "_codif0"}, 32'(bus.mul_codif), 32'd0);
    check({tagName, "_reqRdy"}, 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    int   lat;
    int   enCyc;
    vec_t v;

    vecs[0] = '{CODIF_MUL,    32'd3,        32'd5,        5'h0A, 32'h0000000F, 1'b0, 6, 4};
    vecs[1] = '{CODIF_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'h01, 32'hFFFFFFFE, 1'b0, 6, 4};
    vecs[2] = '{CODIF_MULH,   32'hFFFFFFFF, 32'd2,        5'h02, 32'hFFFFFFFF, 1'b0, 6, 4};
    vecs[3] = '{CODIF_MULHSU, 32'd2,        32'hFFFFFFFF, 5'h03, 32'h00000001, 1'b0, 6, 4};
    vecs[4] = '{CODIF_MUL,    32'd0,        32'd7,        5'h04, 32'h00000000, 1'b0, 1, 0};
    vecs[5] = '{CODIF_MUL,    32'd9,        32'd0,        5'h05, 32'h00000000, 1'b0, 1, 0};
    vecs[6] = '{12'h033,      32'd3,        32'd5,        5'h06, 32'h00000000, 1'b1, 1, 0};
    vecs[7] = '{12'h7FF,      32'd0,        32'd5,        5'h07, 32'h00000000, 1'b1, 1, 0};
    vecs[8] = '{CODIF_MUL,    32'h00010000, 32'h00010000, 5'h08, 32'h00000000, 1'b0, 6, 4};

    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_codif = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_req_ready",  32'(bus.req_ready), 32'd1);
    check("rst_mul_enable", 32'(bus.mul_enable), 32'd0);
    check("rst_mul_codif",  32'(bus.mul_codif), 32'd0);
    check("rst_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data",   bus.rsp_data, 32'd0);
    check("rst_busy",       32'(bus.busy), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      applyStimulus(v.codif, v.rs1, v.rs2, v.tag);
      if (v.expEnCycles > 0) begin
        check($sformatf("v%0d_issue_codif", i), 32'(bus.mul_codif), 32'(v.codif));
        check($sformatf("v%0d_issue_rs1", i), bus.mul_rs1, v.rs1);
      end
      waitResp(lat, enCyc);
      checkOutput($sformatf("v%0d", i), v, lat, enCyc);
      @(negedge clk);
    end

    // Writeback stalls for 10 cycles; the result must sit still.
    bus.rsp_ready = 1'b0;
    applyStimulus(CODIF_MUL, 32'd3, 32'd5, 5'h1F);
    waitResp(lat, enCyc);
    repeat (10) begin
      @(negedge clk);
      check("hold_valid",     32'(bus.rsp_valid), 32'd1);
      check("hold_data",      bus.rsp_data, 32'h0000000F);
      check("hold_tag",       32'(bus.rsp_tag), 32'h1F);
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("hold_release_ready", 32'(bus.req_ready), 32'd1);

    // Reset taken while waiting on MULT.
    tieDoneLow = 1'b1;
    applyStimulus(CODIF_MUL, 32'd3, 32'd5, 5'h11);
    @(negedge clk);
    check("rstw_in_wait", 32'(bus.mul_enable), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rstw_req_ready",  32'(bus.req_ready), 32'd1);
    check("rstw_mul_enable", 32'(bus.mul_enable), 32'd0);
    check("rstw_mul_rs1",    bus.mul_rs1, 32'd0);
    check("rstw_mul_rs2",    bus.mul_rs2, 32'd0);
    check("rstw_mul_codif",  32'(bus.mul_codif), 32'd0);
    check("rstw_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("rstw_rsp_data",   bus.rsp_data, 32'd0);
    check("rstw_rsp_tag",    32'(bus.rsp_tag), 32'd0);
    check("rstw_rsp_err",    32'(bus.rsp_err), 32'd0);
    check("rstw_busy",       32'(bus.busy), 32'd0);
    reset = 1'b1;

    // MULT never answers: ISSUE + TIMEOUT waits + DRAIN, RESP after that.
    applyStimulus(CODIF_MUL, 32'd3, 32'd5, 5'h12);
    waitResp(lat, enCyc);
    check("tmo_err",   32'(bus.rsp_err), 32'd1);
    check("tmo_data",  bus.rsp_data, 32'd0);
    check("tmo_tag",   32'(bus.rsp_tag), 32'h12);
    check("tmo_lat",   32'(lat), 32'(TIMEOUT + 3));
    check("tmo_enCyc", 32'(enCyc), 32'(TIMEOUT + 1));
    @(negedge clk);

    // Flush two cycles into WAIT: one DRAIN cycle, then idle with no response.
    applyStimulus(CODIF_MUL, 32'd3, 32'd5, 5'h13);
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flw_drain_enable", 32'(bus.mul_enable), 32'd0);
    check("flw_drain_busy",   32'(bus.busy), 32'd1);
    check("flw_drain_valid",  32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("flw_idle_busy",  32'(bus.busy), 32'd0);
    check("flw_idle_ready", 32'(bus.req_ready), 32'd1);
    check("flw_idle_codif", 32'(bus.mul_codif), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("flw_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    tieDoneLow = 1'b0;

    // Flush in IDLE blocks a simultaneous request.
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_codif = CODIF_MUL;
    bus.req_rs1   = 32'd3;
    bus.req_rs2   = 32'd5;
    #1;
    check("fli_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("fli_not_busy", 32'(bus.busy), 32'd0);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
